uart_tx_arbiter: RTL
====================

# uart_tx_arbiter

Shares one UART transmit line between `NUM_REQ` byte sources. It arbitrates round-robin and builds the 11-bit frame: start, 8 data bits LSB-first, parity/extra-stop, stop. It generates the bit-period timing from the system clock and shifts the frame onto `tx`. It sits between the modem's byte producers and the physical TX pin, and replaces free-running serialization with a granted, framed, per-byte handshake.

## Interface
- `NUM_REQ`, 4, number of requesters (1..8)
- `CLKS_PER_BIT`, 16, system clocks per UART bit (≥ 2)

- `clock` in 1 system clock, all logic on rising edge
- `reset_n` in 1 asynchronous, active-low reset
- `req` in NUM_REQ, requester i has a byte pending; held until granted
- `data` in NUM_REQ*8, byte of requester i at `data[8*i+7:8*i]`; stable while `req[i]`=1
- `grant` out NUM_REQ, one-hot, one-cycle pulse; the byte of requester i was captured
- `tx` out 1, serial line, idle high
- `busy` out 1, frame in progress
- `frame_done` out 1, one-cycle pulse after the stop bit completes

## Operation
- Reset values: `tx`=1, `grant`=0, `busy`=0, `frame_done`=0, state IDLE, RR pointer=NUM_REQ-1 (requester 0 highest after reset).
- States:
  - IDLE: if `req`≠0 at an edge, the winner is the first set bit scanning from pointer+1 upward with wrap. At that edge:
    - the frame is latched
    - `grant`←onehot(winner)
    - pointer←winner
    - `tx`←0 (start bit)
    - `busy`←1
    - bit index←0, baud count←0
    - go to SHIFT.
  - IDLE with `req`=0: holds `tx`=1.
  - SHIFT: the baud counter runs 0..CLKS_PER_BIT-1. At terminal count the bit index increments and `tx`←frame[index+1]. At terminal count of bit 10 (stop): `tx`←1, `busy`←0, `frame_done`←1, go to IDLE.
- Frame bits:
  - [0]=0
  - [8:1]=data[7:0]
  - [9]=parity or 1 (see Configuration)
  - [10]=1
- `grant` and `frame_done` are high exactly one cycle. `grant` is never asserted outside the IDLE→SHIFT edge.
- `req` changes during SHIFT are ignored. Arbitration happens only in IDLE.
- A requester that keeps `req` high after its grant is treated as presenting a new byte. It competes again at the next IDLE edge.
- `req` bits ≥ NUM_REQ do not exist. A `data` lane is sampled only for the winner.

## Timing
- Latency: `req` sampled at edge E → `grant` and start bit visible from E for one/CLKS_PER_BIT cycles respectively.
- Each bit lasts exactly CLKS_PER_BIT cycles. A frame lasts 11·CLKS_PER_BIT cycles from start-bit edge to the edge that raises `frame_done`.
- Minimum inter-frame gap: 1 cycle (the IDLE cycle carrying `frame_done`, `tx`=1). The next start bit can begin at the following edge.
- Back-to-back throughput: one byte per 11·CLKS_PER_BIT+1 cycles.
- Reset mid-frame: outputs return to reset values immediately (async), the frame is dropped with no `frame_done`, and the pointer is reset.
- Simultaneous requests: exactly one grant per frame. With all requests held, service order is strict rotation.

## Configuration
- `UART_TX_PARITY_EN` defined: frame[9] = even parity = XOR of data[7:0].
- Undefined: frame[9] = 1, giving a second stop bit. Frame length and timing are unchanged.

## Test plan
- CLKS_PER_BIT=4, parity on, req[0] with 0xA5. Required:
  - `tx` per 4-cycle bit = 0,1,0,1,0,0,1,0,1,0,1
  - `grant`=0001 for 1 cycle
  - `frame_done` 44 cycles after the start edge.
- All four `req` held continuously, pointer at reset. Required:
  - grants 0001,0010,0100,1000,0001
  - each pair of grants 45 cycles apart (CLKS_PER_BIT=4)
  - `tx` high exactly 1 cycle between frames.
- req[2] with 0x01, parity on → bit9=1. Same stimulus with `UART_TX_PARITY_EN` undefined → bit9=1. Data 0x03: on → 0, off → 1.
- `reset_n` low during bit 5. Required:
  - `tx`=1, `busy`=0, `grant`=0 immediately
  - no `frame_done`
  - after release, held req[1] is granted first if req[0]=0.
- req[3] pulses and drops mid-frame while req[1] is busy: no grant to 3. Re-raised req[3] is granted only after `frame_done`.
- CLKS_PER_BIT=2 boundary: every bit lasts exactly 2 cycles and the frame lasts 22 cycles.

Source files
------------

// File: rtl/uart_tx_arbiter_if.sv
// uart_tx_arbiter_if: requester byte bus plus serial-line status of uart_tx_arbiter.
interface uart_tx_arbiter_if #(parameter int NUM_REQ = 4);
   logic [NUM_REQ-1:0]   req;
   logic [NUM_REQ*8-1:0] data;
   logic [NUM_REQ-1:0]   grant;
   logic                 tx;
   logic                 busy;
   logic                 frame_done;
   modport master (output req, data, input grant, tx, busy, frame_done);
   modport slave (input req, data, output grant, tx, busy, frame_done);
endinterface

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin shared UART transmitter emitting 11-bit frames.
// Define UART_TX_PARITY_EN for even parity in bit 9; otherwise bit 9 is a second stop bit.
module uart_tx_arbiter #(
   parameter int NUM_REQ      = 4,
   parameter int CLKS_PER_BIT = 16
) (
   input logic              clock_i,
   input logic              reset_n_i,
   uart_tx_arbiter_if.slave bus
);
   localparam int PW = NUM_REQ > 1 ? $clog2(NUM_REQ) : 1;
   localparam int CW = $clog2(CLKS_PER_BIT);
   typedef enum logic {IDLE, SHIFT} state_t;
   state_t             state_q, state_d;
   logic [PW-1:0]      ptr_q, ptr_d, win, win_hi, win_lo;
   logic               hi;
   logic [10:0]        frame_q, frame_d;
   logic [3:0]         idx_q, idx_d;
   logic [CW-1:0]      cnt_q, cnt_d;
   logic [NUM_REQ-1:0] grant_q, grant_d;
   logic               tx_q, tx_d, busy_q, busy_d, done_q, done_d;
   logic [7:0]         byte_w;
   logic               par;
   // Winner is the lowest requester above the pointer, else the lowest overall (wrap).
   always_comb begin
      win_hi = '0;
      win_lo = '0;
      hi = 1'b0;
      byte_w = '0;
      for (int i = NUM_REQ - 1; i >= 0; i--) begin
         if (bus.req[i] && i > int'(ptr_q)) begin
            win_hi = PW'(i);
            hi = 1'b1;
         end
         if (bus.req[i]) win_lo = PW'(i);
      end
      win = hi ? win_hi : win_lo;
      for (int i = 0; i < NUM_REQ; i++)
         if (PW'(i) == win) byte_w = bus.data[8*i +: 8];
`ifdef UART_TX_PARITY_EN
      par = ^byte_w;
`else
      par = 1'b1;
`endif
   end
   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      frame_d = frame_q;
      idx_d   = idx_q;
      cnt_d   = cnt_q;
      grant_d = '0;
      tx_d    = tx_q;
      busy_d  = busy_q;
      done_d  = 1'b0;
      if (state_q == IDLE) begin
         tx_d = 1'b1;
         if (|bus.req) begin
            frame_d = {1'b1, par, byte_w, 1'b0};
            grant_d = NUM_REQ'(1) << win;
            ptr_d   = win;
            tx_d    = 1'b0;
            busy_d  = 1'b1;
            idx_d   = '0;
            cnt_d   = '0;
            state_d = SHIFT;
         end
      end else if (cnt_q == CW'(CLKS_PER_BIT - 1)) begin
         cnt_d = '0;
         if (idx_q == 4'd10) begin
            tx_d    = 1'b1;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            state_d = IDLE;
         end else begin
            idx_d = idx_q + 4'd1;
            tx_d  = frame_q[idx_q + 4'd1];
         end
      end else begin
         cnt_d = cnt_q + CW'(1);
      end
   end
   always_ff @(posedge clock_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         state_q <= IDLE;
         ptr_q   <= PW'(NUM_REQ - 1);
         frame_q <= '1;
         idx_q   <= '0;
         cnt_q   <= '0;
         grant_q <= '0;
         tx_q    <= 1'b1;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         frame_q <= frame_d;
         idx_q   <= idx_d;
         cnt_q   <= cnt_d;
         grant_q <= grant_d;
         tx_q    <= tx_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end
   assign bus.grant      = grant_q;
   assign bus.tx         = tx_q;
   assign bus.busy       = busy_q;
   assign bus.frame_done = done_q;
endmodule
